dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter n, default 32, data and address width in bits.
REQ-002 Parameter CNTW, default 16, width of each per-requester transaction counter.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-005 cpu_req  input  1  CPU access request; held high until cpu_ack.
REQ-006 cpu_we  input  1  CPU write enable (1 = write, 0 = read).
REQ-007 cpu_addr  input  n  CPU byte address.
REQ-008 cpu_wdata  input  n  CPU write data.
REQ-009 cpu_rdata  output  n  CPU read data, registered, valid while cpu_ack = 1.
REQ-010 cpu_ack  output  1  one-cycle completion pulse for CPU.
REQ-011 host_req, host_we, host_addr, host_wdata, host_rdata, host_ack: same widths, directions and meanings as the cpu_* ports, for the host/debug loader.
REQ-012 err  output  1  high with an ack when that transaction was rejected as misaligned.
REQ-013 mem_en  output  1  RAM access strobe, registered.
REQ-014 mem_we  output  1  RAM write enable, registered, only meaningful when mem_en = 1.
REQ-015 mem_addr  output  n  RAM byte address, registered.
REQ-016 mem_wdata  output  n  RAM write data, registered.
REQ-017 mem_rdata  input  n  RAM read data, synchronous, valid one cycle after the mem_en cycle.
REQ-018 cpu_count, host_count  output  CNTW  completed-transaction counters.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, READ, ACK.
REQ-020 In IDLE with no request pending, the FSM SHALL stay in IDLE.
REQ-021 In IDLE with any request pending, the block SHALL grant one requester, latch its we/addr/wdata, and move to ISSUE. A misaligned grant (addr[1:0] != 0) SHALL go directly to ACK instead.
REQ-022 Arbitration SHALL be round-robin. On simultaneous requests, grant the requester not served last. With a single request, grant it regardless of history.
REQ-023 ISSUE SHALL last exactly 1 cycle with mem_en = 1 and mem_we, mem_addr, mem_wdata driven from the latched values, then go to READ.
REQ-024 READ SHALL last 1 cycle; at its end mem_rdata SHALL be captured into the granted requester's rdata register for reads, then go to ACK. Writes leave rdata unchanged.
REQ-025 ACK SHALL last 1 cycle, assert only the granted requester's ack, then return to IDLE.
REQ-026 Latency SHALL be 3 cycles from the IDLE cycle sampling req to the ack cycle; a misaligned request acks in 1 cycle.
REQ-027 Back-to-back aligned transactions SHALL occupy 4 cycles each. req is ignored during ISSUE, READ and ACK, and re-evaluated in IDLE.
REQ-028 mem_en SHALL be 0 in all states except ISSUE; a misaligned request SHALL never assert mem_en.
REQ-029 On misaligned ACK, err SHALL be 1 and the granted rdata SHALL be 0; otherwise err SHALL be 0.
REQ-030 Each counter SHALL increment by 1 on each ack of its requester, including error acks, and saturate at 2**CNTW-1 without wrapping.
REQ-031 The non-granted requester's ack and rdata SHALL be unaffected by the other's transaction.

Reset
REQ-032 While reset = 0: FSM = IDLE; all acks, err, mem_en, mem_we = 0; mem_addr, mem_wdata, both rdata = 0; both counters = 0; round-robin pointer favours CPU next.
REQ-033 Reset asserted mid-transaction SHALL abort it with no ack; mem_en SHALL drop asynchronously.
REQ-034 After reset deasserts, the first request SHALL be sampled on the first rising edge with reset = 1.

Verification
REQ-035 CPU write, addr 84, wdata 0x96 -> mem_en = 1 with we = 1, addr 84, data 0x96 in cycle 1; cpu_ack in cycle 3; cpu_count = 1.
REQ-036 RAM[84] = 0x96, CPU read of addr 84 -> cpu_rdata = 0x96 with cpu_ack in cycle 3; host_ack stays 0.
REQ-037 cpu_req and host_req both held high from reset -> grants CPU, host, CPU, host, with acks at cycles 3, 7, 11, 15.
REQ-038 host read of addr 0x55 -> host_ack and err = 1 in cycle 1; host_rdata = 0; mem_en never 1; host_count = 1.
REQ-039 reset pulsed low during READ of a CPU read -> no cpu_ack; all outputs 0; the next CPU request is serviced normally.
REQ-040 CNTW = 2, five CPU transactions -> cpu_count sequence 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter between a CPU port and a host/debug
// loader port sharing one synchronous single-port data RAM.
//
// Handshake: a requester raises req with we/addr/wdata stable and holds them
// until it sees a one-cycle ack pulse. rdata (reads) and err are valid only
// while that ack is high. req is sampled only while the arbiter is IDLE.
// The RAM side returns mem_rdata one cycle after the cycle with mem_en = 1.
// Misaligned addresses (addr[1:0] != 0) never reach the RAM. They are acked
// one cycle after they are sampled, with err = 1 and rdata = 0.
module dmem_arbiter #(
   parameter int n    = 32,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cpu_req,
   input  logic            cpu_we,
   input  logic [n-1:0]    cpu_addr,
   input  logic [n-1:0]    cpu_wdata,
   output logic [n-1:0]    cpu_rdata,
   output logic            cpu_ack,
   input  logic            host_req,
   input  logic            host_we,
   input  logic [n-1:0]    host_addr,
   input  logic [n-1:0]    host_wdata,
   output logic [n-1:0]    host_rdata,
   output logic            host_ack,
   output logic            err,
   output logic            mem_en,
   output logic            mem_we,
   output logic [n-1:0]    mem_addr,
   output logic [n-1:0]    mem_wdata,
   input  logic [n-1:0]    mem_rdata,
   output logic [CNTW-1:0] cpu_count,
   output logic [CNTW-1:0] host_count,
   output logic [1:0]      dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      READ  = 2'd2,
      ACK   = 2'd3
   } state_t;

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   state_t         state;
   state_t         state_next;
   logic           gnt_host;   // requester owning the transaction in flight
   logic           rr_host;    // 1: host wins the next tie, 0: CPU wins
   logic           lat_we;     // latched write enable of the transaction
   logic           any_req;
   logic           pick_host;
   logic           sel_we;
   logic [n-1:0]   sel_addr;
   logic [n-1:0]   sel_wdata;
   logic           misaligned;
   logic           gnt_next;

   assign dbg_state = state;

   // Arbitration choice, request mux and next-state decode.
   always_comb begin
      any_req    = cpu_req | host_req;
      pick_host  = (cpu_req && host_req) ? rr_host : host_req;
      sel_we     = pick_host ? host_we    : cpu_we;
      sel_addr   = pick_host ? host_addr  : cpu_addr;
      sel_wdata  = pick_host ? host_wdata : cpu_wdata;
      misaligned = (sel_addr[1:0] != 2'b00);
      gnt_next   = (state == IDLE) ? pick_host : gnt_host;
      state_next = state;
      case (state)
         IDLE:    if (any_req) state_next = misaligned ? ACK : ISSUE;
         ISSUE:   state_next = READ;
         READ:    state_next = ACK;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Grant latch, round-robin pointer, RAM strobes and ack/err pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_host  <= 1'b0;
         rr_host   <= 1'b0;
         lat_we    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_ack   <= 1'b0;
         host_ack  <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (state == IDLE && any_req) begin
            gnt_host <= pick_host;
            rr_host  <= !pick_host;
            lat_we   <= sel_we;
         end
         mem_en <= (state_next == ISSUE);
         mem_we <= (state_next == ISSUE) && sel_we;
         if (state_next == ISSUE) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
         end
         cpu_ack  <= (state_next == ACK) && !gnt_next;
         host_ack <= (state_next == ACK) && gnt_next;
         err      <= (state == IDLE) && (state_next == ACK);
      end
   end

   // Per-requester read data and saturating transaction counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_rdata  <= '0;
         host_rdata <= '0;
         cpu_count  <= '0;
         host_count <= '0;
      end else begin
         if (state == READ && !lat_we) begin
            if (gnt_host) host_rdata <= mem_rdata;
            else          cpu_rdata  <= mem_rdata;
         end
         if (state == IDLE && state_next == ACK) begin
            if (pick_host) host_rdata <= '0;
            else           cpu_rdata  <= '0;
         end
         if (state_next == ACK) begin
            if (gnt_next) begin
               if (host_count != CNT_MAX) host_count <= host_count + CNTW'(1);
            end else begin
               if (cpu_count != CNT_MAX) cpu_count <= cpu_count + CNTW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: transaction-level checks of dmem_arbiter against a
// memory/counter reference model, plus a CNTW = 2 instance for saturation.
module tb_dmem_arbiter;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [W-1:0]  cpu_addr = '0, cpu_wdata = '0;
   logic          host_req = 1'b0, host_we = 1'b0;
   logic [W-1:0]  host_addr = '0, host_wdata = '0;
   logic [W-1:0]  cpu_rdata, host_rdata, mem_addr, mem_wdata;
   logic [W-1:0]  mem_rdata = '0;
   logic          cpu_ack, host_ack, err, mem_en, mem_we;
   logic [15:0]   cpu_count, host_count;
   logic [1:0]    dbg_state;

   logic [W-1:0]  s_cpu_rdata, s_host_rdata, s_mem_addr, s_mem_wdata;
   logic          s_cpu_ack, s_host_ack, s_err, s_mem_en, s_mem_we;
   logic [1:0]    s_cpu_count, s_host_count, s_dbg_state;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [W-1:0]  ref_mem [0:255];
   logic [W-1:0]  exp_cpu_rd, exp_host_rd;
   int            exp_cpu_cnt, exp_host_cnt;
   bit            last_host;          // requester served most recently
   logic [W-1:0]  exp_q[$];

   // bench RAM: synchronous, one-cycle read latency
   logic [W-1:0]  ram [0:255];

   dmem_arbiter #(.n(W), .CNTW(16)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata), .host_ack(host_ack),
      .err(err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .cpu_count(cpu_count), .host_count(host_count), .dbg_state(dbg_state)
   );

   dmem_arbiter #(.n(W), .CNTW(2)) sat_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(s_cpu_rdata), .cpu_ack(s_cpu_ack),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(s_host_rdata), .host_ack(s_host_ack),
      .err(s_err), .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
      .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
      .cpu_count(s_cpu_count), .host_count(s_host_count), .dbg_state(s_dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr[9:2]];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic model_reset();
      exp_cpu_rd   = '0;
      exp_host_rd  = '0;
      exp_cpu_cnt  = 0;
      exp_host_cnt = 0;
      last_host    = 1'b1;
   endtask

   // driver: one transaction from one requester; reports what it observed
   task automatic do_txn(input bit host, input bit we, input logic [W-1:0] addr,
                         input logic [W-1:0] wdata, output int lat,
                         output logic [W-1:0] rdata, output bit err_o,
                         output int en_cnt, output int en_cyc, output bit m_we,
                         output logic [W-1:0] m_addr, output logic [W-1:0] m_wdata,
                         output bit other_ack, output logic [15:0] count_o);
      lat = 0; rdata = '0; err_o = 1'b0; en_cnt = 0; en_cyc = 0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; other_ack = 1'b0;
      if (host) begin
         host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (mem_en) begin
            if (en_cnt == 0) begin
               en_cyc = c; m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
            end
            en_cnt++;
         end
         if (host ? cpu_ack : host_ack) other_ack = 1'b1;
         if (host ? host_ack : cpu_ack) begin
            lat = c;
            rdata = host ? host_rdata : cpu_rdata;
            err_o = err;
            break;
         end
      end
      cpu_req = 1'b0; host_req = 1'b0;
      tick();
      if (mem_en) en_cnt++;
      count_o = host ? host_count : cpu_count;
   endtask

   // model update for one completed transaction; returns expected values
   task automatic model_txn(input bit host, input bit we, input logic [W-1:0] addr,
                            input logic [W-1:0] wdata, output logic [W-1:0] exp_rd,
                            output int exp_cnt);
      if (addr[1:0] != 2'b00)  exp_rd = '0;
      else if (!we)            exp_rd = ref_mem[addr[9:2]];
      else                     exp_rd = host ? exp_host_rd : exp_cpu_rd;
      if (addr[1:0] == 2'b00 && we) ref_mem[addr[9:2]] = wdata;
      if (host) begin
         exp_host_rd = exp_rd;
         if (exp_host_cnt < 65535) exp_host_cnt++;
         exp_cnt = exp_host_cnt;
      end else begin
         exp_cpu_rd = exp_rd;
         if (exp_cpu_cnt < 65535) exp_cpu_cnt++;
         exp_cnt = exp_cpu_cnt;
      end
      last_host = host;
   endtask

   task automatic test_reset();
      apply_reset();
      reset = 1'b0;
      tick();
      checks++;
      if ({cpu_ack, host_ack, err, mem_en, mem_we} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl: ack/err/en/we=%b required 00000", {cpu_ack, host_ack, err, mem_en, mem_we});
      end
      checks++;
      if ({mem_addr, mem_wdata, cpu_rdata, host_rdata} !== '0) begin
         failures++;
         $display("FAIL reset_data: addr=%h wdata=%h crd=%h hrd=%h required 0", mem_addr, mem_wdata, cpu_rdata, host_rdata);
      end
      checks++;
      if ({cpu_count, host_count, s_cpu_count, s_host_count} !== '0) begin
         failures++;
         $display("FAIL reset_count: cpu=%0d host=%0d required 0", cpu_count, host_count);
      end
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_write_read();
      int lat, en_cnt, en_cyc, exp_cnt;
      logic [W-1:0] rd, ma, mw, exp_rd;
      logic [15:0] cnt;
      bit e, mwe, oth;
      do_txn(1'b0, 1'b1, 32'd84, 32'h96, lat, rd, e, en_cnt, en_cyc, mwe, ma, mw, oth, cnt);
      model_txn(1'b0, 1'b1, 32'd84, 32'h96, exp_rd, exp_cnt);
      checks++;
      if (lat !== 3 || en_cyc !== 1 || en_cnt !== 1) begin
         failures++;
         $display("FAIL wr_timing: ack_cycle=%0d en_cycle=%0d en_cycles=%0d required 3/1/1", lat, en_cyc, en_cnt);
      end
      checks++;
      if (mwe !== 1'b1 || ma !== 32'd84 || mw !== 32'h96) begin
         failures++;
         $display("FAIL wr_mem: we=%b addr=%0d data=%h required 1/84/96", mwe, ma, mw);
      end
      checks++;
      if (cnt !== exp_cnt[15:0] || e !== 1'b0) begin
         failures++;
         $display("FAIL wr_count: count=%0d err=%b required %0d/0", cnt, e, exp_cnt);
      end
      do_txn(1'b0, 1'b0, 32'd84, 32'h0, lat, rd, e, en_cnt, en_cyc, mwe, ma, mw, oth, cnt);
      model_txn(1'b0, 1'b0, 32'd84, 32'h0, exp_rd, exp_cnt);
      checks++;
      if (rd !== exp_rd || lat !== 3) begin
         failures++;
         $display("FAIL rd_data: rdata=%h ack_cycle=%0d required %h/3", rd, lat, exp_rd);
      end
      checks++;
      if (oth !== 1'b0 || mwe !== 1'b0) begin
         failures++;
         $display("FAIL rd_other: host_ack_seen=%b mem_we=%b required 0/0", oth, mwe);
      end
   endtask

   task automatic test_misaligned();
      int lat, en_cnt, en_cyc, exp_cnt;
      logic [W-1:0] rd, ma, mw, exp_rd;
      logic [15:0] cnt;
      bit e, mwe, oth;
      // make host_rdata non-zero first so the clear is visible
      do_txn(1'b1, 1'b0, 32'd84, 32'h0, lat, rd, e, en_cnt, en_cyc, mwe, ma, mw, oth, cnt);
      model_txn(1'b1, 1'b0, 32'd84, 32'h0, exp_rd, exp_cnt);
      checks++;
      if (rd !== exp_rd) begin
         failures++;
         $display("FAIL host_rd: rdata=%h required %h", rd, exp_rd);
      end
      do_txn(1'b1, 1'b0, 32'h55, 32'h0, lat, rd, e, en_cnt, en_cyc, mwe, ma, mw, oth, cnt);
      model_txn(1'b1, 1'b0, 32'h55, 32'h0, exp_rd, exp_cnt);
      checks++;
      if (lat !== 1 || e !== 1'b1 || rd !== '0) begin
         failures++;
         $display("FAIL mis_ack: ack_cycle=%0d err=%b rdata=%h required 1/1/0", lat, e, rd);
      end
      checks++;
      if (en_cnt !== 0 || cnt !== exp_cnt[15:0] || oth !== 1'b0) begin
         failures++;
         $display("FAIL mis_side: en_cycles=%0d count=%0d cpu_ack_seen=%b required 0/%0d/0", en_cnt, cnt, oth, exp_cnt);
      end
   endtask

   task automatic test_random();
      int lat, en_cnt, en_cyc, exp_cnt;
      logic [W-1:0] rd, ma, mw, exp_rd, addr, wdata, other_rd, exp_other;
      logic [15:0] cnt;
      bit e, mwe, oth, host, we, mis;
      for (int i = 0; i < 40; i++) begin
         host  = 1'($urandom_range(0, 1));
         we    = 1'($urandom_range(0, 1));
         addr  = W'($urandom_range(0, 255)) << 2;
         if ($urandom_range(0, 3) == 0) addr = addr | W'($urandom_range(1, 3));
         wdata = $urandom;
         mis   = (addr[1:0] != 2'b00);
         do_txn(host, we, addr, wdata, lat, rd, e, en_cnt, en_cyc, mwe, ma, mw, oth, cnt);
         model_txn(host, we, addr, wdata, exp_rd, exp_cnt);
         exp_q.push_back(exp_rd);
         exp_other = host ? exp_cpu_rd : exp_host_rd;
         other_rd  = host ? cpu_rdata : host_rdata;
         checks++;
         if (rd !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL rand_rdata[%0d]: rdata=%h required %h", i, rd, exp_rd);
         end
         checks++;
         if (lat !== (mis ? 1 : 3) || e !== mis || en_cnt !== (mis ? 0 : 1)) begin
            failures++;
            $display("FAIL rand_timing[%0d]: ack_cycle=%0d err=%b en_cycles=%0d mis=%b", i, lat, e, en_cnt, mis);
         end
         checks++;
         if (cnt !== exp_cnt[15:0] || oth !== 1'b0 || other_rd !== exp_other) begin
            failures++;
            $display("FAIL rand_side[%0d]: count=%0d/%0d other_ack=%b other_rdata=%h/%h", i, cnt, exp_cnt, oth, other_rd, exp_other);
         end
         if (!mis) begin
            checks++;
            if (mwe !== we || ma !== addr || (we && mw !== wdata)) begin
               failures++;
               $display("FAIL rand_mem[%0d]: we=%b addr=%h data=%h required %b/%h/%h", i, mwe, ma, mw, we, addr, wdata);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc_q[$];
      int who_q[$];
      int exp_cyc, exp_cnt;
      bit exp_host;
      logic [W-1:0] exp_rd;
      reset = 1'b0;
      cpu_req = 1'b1;  cpu_we = 1'b0;  cpu_addr = 32'd84;
      host_req = 1'b1; host_we = 1'b0; host_addr = 32'd8;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      reset = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (cpu_ack)  begin cyc_q.push_back(c); who_q.push_back(0); end
         if (host_ack) begin cyc_q.push_back(c); who_q.push_back(1); end
      end
      cpu_req = 1'b0; host_req = 1'b0;
      tick();
      tick();
      checks++;
      if (cyc_q.size() !== 4) begin
         failures++;
         $display("FAIL b2b_count: acks=%0d required 4", cyc_q.size());
      end
      exp_cyc = 3;
      for (int k = 0; k < 4; k++) begin
         exp_host = !last_host;
         model_txn(exp_host, 1'b0, exp_host ? 32'd8 : 32'd84, '0, exp_rd, exp_cnt);
         if (k < cyc_q.size()) begin
            checks++;
            if (cyc_q[k] !== exp_cyc || who_q[k] !== int'(exp_host)) begin
               failures++;
               $display("FAIL b2b_grant[%0d]: cycle=%0d host=%0d required %0d/%0d", k, cyc_q[k], who_q[k], exp_cyc, exp_host);
            end
         end
         exp_cyc += 4;
      end
      checks++;
      if (cpu_count !== 16'(exp_cpu_cnt) || host_count !== 16'(exp_host_cnt) ||
          cpu_rdata !== exp_cpu_rd || host_rdata !== exp_host_rd) begin
         failures++;
         $display("FAIL b2b_state: counts=%0d/%0d rdata=%h/%h required %0d/%0d %h/%h",
                  cpu_count, host_count, cpu_rdata, host_rdata, exp_cpu_cnt, exp_host_cnt, exp_cpu_rd, exp_host_rd);
      end
   endtask

   // both requesters raise req together; each drops it on its own ack
   task automatic test_rr_history();
      int lat, en_cnt, en_cyc, exp_cnt, n_ack;
      int cyc_a [2];
      int who_a [2];
      logic [W-1:0] rd, ma, mw, exp_rd;
      logic [15:0] cnt;
      bit e, mwe, oth, exp_first;
      for (int r = 0; r < 2; r++) begin
         // r=0: CPU served last -> host wins the tie; r=1: host served last
         do_txn(r == 1, 1'b0, 32'd84, '0, lat, rd, e, en_cnt, en_cyc, mwe, ma, mw, oth, cnt);
         model_txn(r == 1, 1'b0, 32'd84, '0, exp_rd, exp_cnt);
         exp_first = !last_host;
         cpu_req = 1'b1;  cpu_we = 1'b0;  cpu_addr = 32'd84;
         host_req = 1'b1; host_we = 1'b0; host_addr = 32'd8;
         n_ack = 0;
         for (int c = 1; c <= 20 && n_ack < 2; c++) begin
            tick();
            if (cpu_ack && n_ack < 2)  begin cyc_a[n_ack] = c; who_a[n_ack] = 0; n_ack++; cpu_req = 1'b0; end
            if (host_ack && n_ack < 2) begin cyc_a[n_ack] = c; who_a[n_ack] = 1; n_ack++; host_req = 1'b0; end
         end
         cpu_req = 1'b0; host_req = 1'b0;
         tick();
         model_txn(exp_first, 1'b0, exp_first ? 32'd8 : 32'd84, '0, exp_rd, exp_cnt);
         model_txn(!exp_first, 1'b0, exp_first ? 32'd84 : 32'd8, '0, exp_rd, exp_cnt);
         checks++;
         if (n_ack !== 2 || who_a[0] !== int'(exp_first) || who_a[1] !== int'(!exp_first) ||
             cyc_a[0] !== 3 || cyc_a[1] !== 7) begin
            failures++;
            $display("FAIL rr_tie[%0d]: acks=%0d first=%0d@%0d second=%0d@%0d required first=%0d@3 second@7",
                     r, n_ack, who_a[0], cyc_a[0], who_a[1], cyc_a[1], exp_first);
         end
      end
   endtask

   task automatic test_reset_abort();
      int lat, en_cnt, en_cyc, exp_cnt;
      logic [W-1:0] rd, ma, mw, exp_rd;
      logic [15:0] cnt;
      bit e, mwe, oth, ack_seen;
      do_txn(1'b0, 1'b1, 32'd200, 32'hCAFE_0123, lat, rd, e, en_cnt, en_cyc, mwe, ma, mw, oth, cnt);
      model_txn(1'b0, 1'b1, 32'd200, 32'hCAFE_0123, exp_rd, exp_cnt);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd200;
      tick();               // ISSUE
      tick();               // READ
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({cpu_ack, host_ack, err, mem_en, mem_we} !== 5'b0 ||
          {mem_addr, cpu_rdata, host_rdata, cpu_count, host_count} !== '0) begin
         failures++;
         $display("FAIL abort_outputs: ack=%b en=%b addr=%h crd=%h cnt=%0d required all 0", cpu_ack, mem_en, mem_addr, cpu_rdata, cpu_count);
      end
      cpu_req = 1'b0;
      ack_seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (cpu_ack || host_ack) ack_seen = 1'b1;
      end
      reset = 1'b1;
      model_reset();
      tick();
      if (cpu_ack || host_ack) ack_seen = 1'b1;
      checks++;
      if (ack_seen !== 1'b0) begin
         failures++;
         $display("FAIL abort_noack: ack seen after abort, required none");
      end
      do_txn(1'b0, 1'b0, 32'd200, '0, lat, rd, e, en_cnt, en_cyc, mwe, ma, mw, oth, cnt);
      model_txn(1'b0, 1'b0, 32'd200, '0, exp_rd, exp_cnt);
      checks++;
      if (rd !== exp_rd || lat !== 3 || cnt !== exp_cnt[15:0]) begin
         failures++;
         $display("FAIL abort_recover: rdata=%h ack_cycle=%0d count=%0d required %h/3/%0d", rd, lat, cnt, exp_rd, exp_cnt);
      end
   endtask

   task automatic test_saturation();
      int lat, en_cnt, en_cyc, exp_cnt, exp_sat;
      logic [W-1:0] rd, ma, mw, exp_rd;
      logic [15:0] cnt;
      bit e, mwe, oth;
      apply_reset();
      model_reset();
      exp_sat = 0;
      for (int k = 1; k <= 5; k++) begin
         do_txn(1'b0, 1'b1, W'(k * 4), W'(k), lat, rd, e, en_cnt, en_cyc, mwe, ma, mw, oth, cnt);
         model_txn(1'b0, 1'b1, W'(k * 4), W'(k), exp_rd, exp_cnt);
         if (exp_sat < 3) exp_sat++;
         checks++;
         if (s_cpu_count !== 2'(exp_sat) || cnt !== exp_cnt[15:0]) begin
            failures++;
            $display("FAIL sat_count[%0d]: small=%0d wide=%0d required %0d/%0d", k, s_cpu_count, cnt, exp_sat, exp_cnt);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i] = '0;
         ref_mem[i] = '0;
      end
      model_reset();
      test_reset();
      test_write_read();
      test_misaligned();
      test_random();
      test_back_to_back();
      test_rr_history();
      test_reset_abort();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
